strided_pingpong_buffer: RTL and testbench

STRIDED_PINGPONG_BUFFER -- requirements
Module: strided_pingpong_buffer

---
 rtl/strided_pingpong_buffer_if.sv | 16 +
 rtl/strided_pingpong_buffer.sv | 166 ++++++++++++++++
 tb/tb_strided_pingpong_buffer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/strided_pingpong_buffer_if.sv
// Write-stream interface for strided_pingpong_buffer.
// Handshake: a beat transfers on a rising clk edge where s_valid and s_ready
// are both high; s_data must be stable while s_valid is high, and the master
// may assert s_valid without waiting for s_ready.
//   master : drives s_valid, s_data; observes s_ready
//   slave  : observes s_valid, s_data; drives s_ready
interface strided_pingpong_buffer_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/strided_pingpong_buffer.sv
// Strided ping-pong buffer. An input stream scanned c-fastest, then y, then x
// is scattered into N_BANK column banks (bank = x mod N_BANK) so that a reader
// can fetch N_BANK adjacent columns in one cycle. Each bank has two halves;
// the writer fills half 'tog' while the reader consumes half 'rd_half'.
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   clr            soft clear (same effect as reset, wins over s_valid/release)
//   shape          {n_wrap_c, h, w}, latched on the first beat of a frame
//   s_if           write stream (slave modport)
//   rd_en, rdaddr  read strobe and per-bank word offsets into half rd_half
//   dout, do_valid read data, one cycle after rd_en; dout holds otherwise
//   release_half   frees the half being read (ignored if it is not full)
//   full, rd_half, tog, frame_done, cur_coord  status
//   dbg_state      1 while a frame is in progress (shape latched)
module strided_pingpong_buffer #(
  parameter int N_BANK     = 5,
  parameter int B_BUF_ADDR = 10,
  parameter int B_COORD    = 9,
  parameter int B_WRAP_C   = 7,
  parameter int DATA_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             clr,
  input  logic [2*B_COORD+B_WRAP_C-1:0]    shape,
  strided_pingpong_buffer_if.slave         s_if,
  input  logic                             rd_en,
  input  logic [N_BANK*(B_BUF_ADDR-1)-1:0] rdaddr,
  output logic [N_BANK*DATA_WIDTH-1:0]     dout,
  output logic                             do_valid,
  input  logic                             release_half,
  output logic [1:0]                       full,
  output logic                             rd_half,
  output logic                             tog,
  output logic                             frame_done,
  output logic [2*B_COORD+B_WRAP_C-1:0]    cur_coord,
  output logic                             dbg_state
);
  localparam int OW = B_BUF_ADDR - 1;
  localparam int SW = 2*B_COORD + B_WRAP_C;
  localparam int BW = (N_BANK > 1) ? $clog2(N_BANK) : 1;

  typedef enum logic {ST_IDLE, ST_FILL} state_t;
  state_t state_q, state_d;

  logic [B_COORD-1:0]  x_q, y_q;
  logic [B_WRAP_C-1:0] c_q;
  logic [BW-1:0]       bank_q;
  logic [OW-1:0]       off_q [N_BANK];
  logic [SW-1:0]       shape_q, shape_eff;
  logic [B_COORD-1:0]  w_m1, h_m1;
  logic [B_WRAP_C-1:0] nc_m1;
  logic                c_last, y_last, x_last, frame_last;
  logic                accept, rel_ok;
  logic [1:0]          full_n;

  // The first beat of a frame sees the live shape; later beats the latched one.
  assign shape_eff = (state_q == ST_IDLE) ? shape : shape_q;

  // A zero-sized field behaves as size 1, so its last index is 0.
  always_comb begin
    w_m1  = shape_eff[B_COORD-1:0];
    h_m1  = shape_eff[2*B_COORD-1:B_COORD];
    nc_m1 = shape_eff[SW-1:2*B_COORD];
    if (w_m1  != '0) w_m1  = w_m1  - 1'b1;
    if (h_m1  != '0) h_m1  = h_m1  - 1'b1;
    if (nc_m1 != '0) nc_m1 = nc_m1 - 1'b1;
  end

  assign c_last     = (c_q == nc_m1);
  assign y_last     = (y_q == h_m1);
  assign x_last     = (x_q == w_m1);
  assign frame_last = c_last & y_last & x_last;

  // clr/reset suppress the write even though s_ready may read 1 that cycle.
  assign s_if.s_ready = ~full[tog];
  assign accept       = s_if.s_valid & ~full[tog] & rstn & ~clr;
  assign rel_ok       = release_half & full[rd_half];
  assign cur_coord    = {c_q, y_q, x_q};
  assign dbg_state    = (state_q == ST_FILL);

  // Completion and release touch different halves whenever both are legal,
  // so applying both to a copy of the flags is safe.
  always_comb begin
    full_n = full;
    if (accept && frame_last) full_n[tog] = 1'b1;
    if (rel_ok)               full_n[rd_half] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && !frame_last) state_d = ST_FILL;
      ST_FILL: if (accept && frame_last)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      x_q        <= '0;
      y_q        <= '0;
      c_q        <= '0;
      bank_q     <= '0;
      shape_q    <= '0;
      tog        <= 1'b0;
      rd_half    <= 1'b0;
      full       <= 2'b00;
      frame_done <= 1'b0;
      do_valid   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      do_valid   <= rd_en;
      full       <= full_n;
      if (rel_ok) rd_half <= ~rd_half;
      if (accept) begin
        if (state_q == ST_IDLE) shape_q <= shape;
        if (frame_last) begin
          x_q        <= '0;
          y_q        <= '0;
          c_q        <= '0;
          bank_q     <= '0;
          tog        <= ~tog;
          frame_done <= 1'b1;
        end else if (!c_last) begin
          c_q <= c_q + 1'b1;
        end else begin
          c_q <= '0;
          if (!y_last) begin
            y_q <= y_q + 1'b1;
          end else begin
            // Column complete: advance x and its mod-N_BANK shadow together.
            y_q    <= '0;
            x_q    <= x_q + 1'b1;
            bank_q <= (bank_q == BW'(N_BANK-1)) ? '0 : bank_q + 1'b1;
          end
        end
      end
    end
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [2**B_BUF_ADDR];
    logic [DATA_WIDTH-1:0] rd_q;

    // Offsets wrap naturally on overflow.
    always_ff @(posedge clk) begin
      if (!rstn || clr)                   off_q[b] <= '0;
      else if (accept && frame_last)      off_q[b] <= '0;
      else if (accept && bank_q == BW'(b)) off_q[b] <= off_q[b] + 1'b1;
    end

    // RAM has no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
      if (accept && bank_q == BW'(b)) mem[{tog, off_q[b]}] <= s_if.s_data;
      if (rd_en) rd_q <= mem[{rd_half, rdaddr[b*OW +: OW]}];
    end

    assign dout[b*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end
endmodule

// File: tb/tb_strided_pingpong_buffer.sv
module tb_strided_pingpong_buffer;
  localparam int N_BANK = 5;
  localparam int B_BUF_ADDR = 10;
  localparam int B_COORD = 9;
  localparam int B_WRAP_C = 7;
  localparam int DW = 64;
  localparam int OW = B_BUF_ADDR - 1;
  localparam int SW = 2*B_COORD + B_WRAP_C;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 clr = 1'b0;
  logic [SW-1:0]        shape = '0;
  logic                 rd_en = 1'b0;
  logic [N_BANK*OW-1:0] rdaddr = '0;
  logic [N_BANK*DW-1:0] dout;
  logic                 do_valid;
  logic                 release_half = 1'b0;
  logic [1:0]           full;
  logic                 rd_half, tog, frame_done, dbg_state;
  logic [SW-1:0]        cur_coord;

  int n_tests = 0;
  int n_fail = 0;

  strided_pingpong_buffer_if #(.DATA_WIDTH(DW)) s_if ();

  strided_pingpong_buffer #(
    .N_BANK(N_BANK), .B_BUF_ADDR(B_BUF_ADDR), .B_COORD(B_COORD),
    .B_WRAP_C(B_WRAP_C), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .shape(shape), .s_if(s_if.slave),
    .rd_en(rd_en), .rdaddr(rdaddr), .dout(dout), .do_valid(do_valid),
    .release_half(release_half), .full(full), .rd_half(rd_half), .tog(tog),
    .frame_done(frame_done), .cur_coord(cur_coord), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          bank;
    int          off;
    logic [63:0] exp;
  } rd_vec_t;
  rd_vec_t vecs[10];

  function automatic logic [SW-1:0] mk_shape(int nc, int h, int w);
    return {B_WRAP_C'(nc), B_COORD'(h), B_COORD'(w)};
  endfunction

  function automatic logic [SW-1:0] mk_coord(int c, int y, int x);
    return {B_WRAP_C'(c), B_COORD'(y), B_COORD'(x)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One read of a single bank from the current read half.
  task automatic read_one(string name, int bank, int off, logic [63:0] exp);
    rdaddr = '0;
    rdaddr[bank*OW +: OW] = OW'(off);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({name, "_valid"}, {63'd0, do_valid}, 64'd1);
    check(name, dout[bank*DW +: DW], exp);
  endtask

  // Streams n beats of shape sh with data base+i, no bubbles.
  task automatic stream(int n, logic [SW-1:0] sh, int base);
    shape = sh;
    for (int i = 0; i < n; i++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = DW'(base + i);
      tick();
    end
    s_if.s_valid = 1'b0;
  endtask

  initial begin
    int ready_miss, done_early;
    logic [63:0] last;

    // Beat i of frame 1 (w=10,h=2,nc=3): x=i/6, bank=x%5, off=(x/5)*6+i%6.
    vecs[0] = '{0, 0, 64'd0};
    vecs[1] = '{0, 5, 64'd5};
    vecs[2] = '{0, 6, 64'd30};
    vecs[3] = '{0, 11, 64'd35};
    vecs[4] = '{1, 0, 64'd6};
    vecs[5] = '{1, 7, 64'd37};
    vecs[6] = '{2, 3, 64'd15};
    vecs[7] = '{3, 8, 64'd50};
    vecs[8] = '{4, 11, 64'd59};
    vecs[9] = '{4, 0, 64'd24};

    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;

    // reset
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    check("rst_full", 64'(full), 64'd0);
    check("rst_tog", 64'(tog), 64'd0);
    check("rst_rd_half", 64'(rd_half), 64'd0);
    check("rst_ready", 64'(s_if.s_ready), 64'd1);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_do_valid", 64'(do_valid), 64'd0);
    check("rst_coord", 64'(cur_coord), 64'd0);

    // Frame 1: 60 beats, shape input changed after the first beat.
    ready_miss = 0;
    done_early = 0;
    shape = mk_shape(3, 2, 10);
    for (int i = 0; i < 60; i++) begin
      if (!s_if.s_ready) ready_miss++;
      s_if.s_valid = 1'b1;
      s_if.s_data  = DW'(i);
      tick();
      if (i == 0) shape = mk_shape(1, 1, 1);
      if (i == 6) check("f1_coord_b7", 64'(cur_coord), 64'(mk_coord(1, 0, 1)));
      if (i < 59 && frame_done) done_early++;
    end
    s_if.s_valid = 1'b0;
    check("f1_ready_misses", 64'(ready_miss), 64'd0);
    check("f1_done_early", 64'(done_early), 64'd0);
    check("f1_done", 64'(frame_done), 64'd1);
    check("f1_full", 64'(full), 64'd1);
    check("f1_tog", 64'(tog), 64'd1);
    check("f1_coord", 64'(cur_coord), 64'd0);
    tick();
    check("f1_done_pulse", 64'(frame_done), 64'd0);

    // Table of single-bank reads from half 0.
    for (int k = 0; k < 10; k++) begin
      read_one($sformatf("rd_vec%0d", k), vecs[k].bank, vecs[k].off, vecs[k].exp);
      last = vecs[k].exp;
    end
    tick();
    check("rd_idle_valid", 64'(do_valid), 64'd0);
    check("rd_hold", dout[4*DW +: DW], last);

    // All banks at offset 3 in one read.
    for (int b = 0; b < N_BANK; b++) rdaddr[b*OW +: OW] = OW'(3);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("rd_all_valid", 64'(do_valid), 64'd1);
    for (int b = 0; b < N_BANK; b++)
      check($sformatf("rd_all_b%0d", b), dout[b*DW +: DW], 64'(6*b + 3));

    // Frame 2 into half 1: w=1,h=1,nc=3, c counts 0,1,2.
    shape = mk_shape(3, 1, 1);
    s_if.s_valid = 1'b1;
    s_if.s_data = 64'd100;
    tick();
    check("f2_coord_c1", 64'(cur_coord), 64'(mk_coord(1, 0, 0)));
    s_if.s_data = 64'd101;
    tick();
    check("f2_coord_c2", 64'(cur_coord), 64'(mk_coord(2, 0, 0)));
    s_if.s_data = 64'd102;
    tick();
    check("f2_done", 64'(frame_done), 64'd1);
    check("f2_coord", 64'(cur_coord), 64'd0);
    check("f2_full", 64'(full), 64'd3);
    check("f2_tog", 64'(tog), 64'd0);
    check("f2_ready", 64'(s_if.s_ready), 64'd0);

    // Both halves full: s_valid held, nothing may be written.
    s_if.s_data = 64'hdead;
    for (int i = 0; i < 4; i++) tick();
    check("hold_ready", 64'(s_if.s_ready), 64'd0);
    check("hold_coord", 64'(cur_coord), 64'd0);
    read_one("hold_no_write", 0, 0, 64'd0);
    release_half = 1'b1;
    tick();
    release_half = 1'b0;
    s_if.s_valid = 1'b0;
    check("rel_rd_half", 64'(rd_half), 64'd1);
    check("rel_full", 64'(full), 64'd2);
    check("rel_ready", 64'(s_if.s_ready), 64'd1);
    read_one("h1_b0_o0", 0, 0, 64'd100);
    read_one("h1_b0_o2", 0, 2, 64'd102);

    // clr on the 17th cycle of a frame, together with s_valid.
    stream(16, mk_shape(3, 2, 10), 1000);
    s_if.s_valid = 1'b1;
    s_if.s_data = 64'd1016;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    s_if.s_valid = 1'b0;
    check("clr_coord", 64'(cur_coord), 64'd0);
    check("clr_full", 64'(full), 64'd0);
    check("clr_tog", 64'(tog), 64'd0);
    check("clr_rd_half", 64'(rd_half), 64'd0);
    check("clr_ready", 64'(s_if.s_ready), 64'd1);

    // All-zero shape acts as a single-beat frame starting at offset 0.
    stream(1, mk_shape(0, 0, 0), 'hABC);
    check("deg_done", 64'(frame_done), 64'd1);
    check("deg_full", 64'(full), 64'd1);
    check("deg_tog", 64'(tog), 64'd1);
    read_one("clr_b0_o0", 0, 0, 64'hABC);
    read_one("clr_b0_o1", 0, 1, 64'd1001);
    read_one("clr_b2_o3", 2, 3, 64'd1015);
    read_one("clr_b2_o4", 2, 4, 64'd16);

    // Last beat into half 1 together with release of half 0.
    shape = mk_shape(2, 1, 1);
    s_if.s_valid = 1'b1;
    s_if.s_data = 64'd200;
    tick();
    s_if.s_data = 64'd201;
    release_half = 1'b1;
    tick();
    release_half = 1'b0;
    s_if.s_valid = 1'b0;
    check("same_done", 64'(frame_done), 64'd1);
    check("same_full", 64'(full), 64'd2);
    check("same_rd_half", 64'(rd_half), 64'd1);
    check("same_tog", 64'(tog), 64'd0);
    check("same_ready", 64'(s_if.s_ready), 64'd1);
    read_one("same_b0_o1", 0, 1, 64'd201);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
